alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid_i (N=0,1)  in  1  requester N presents an operation.
REQ-005 reqN_ready_o  out  1  arbiter accepts requester N this cycle.
REQ-006 reqN_funct7_i  in  1  funct7 selector bit for requester N.
REQ-007 reqN_alu_op_i  in  3  ALU_Op code for requester N.
REQ-008 reqN_funct3_i  in  3  funct3 field for requester N.
REQ-009 reqN_a_i, reqN_b_i  in  DATA_WIDTH  operands for requester N.
REQ-010 alu_funct7_o, alu_op_o[2:0], alu_funct3_o[2:0]  out  selector fields driven to the shared ALU and its control decode.
REQ-011 alu_a_o, alu_b_o  out  DATA_WIDTH  operands driven to the shared ALU.
REQ-012 alu_result_i  in  DATA_WIDTH  combinational result from the shared ALU.
REQ-013 rsp_valid_o  out  1  response holds a valid result.
REQ-014 rsp_ready_i  in  1  consumer accepts the response.
REQ-015 rsp_id_o  out  1  index of the requester that owns the response.
REQ-016 rsp_data_o  out  DATA_WIDTH  registered ALU result.
REQ-017 busy_o  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC, and RESP.
REQ-019 IDLE: if any valid is high, exactly one reqN_ready_o SHALL be high (combinational), and both ready outputs SHALL be low in EXEC and RESP.
REQ-020 Grant: if only one requester is valid, it is granted; if both are valid, the requester not granted last is granted (round-robin).
REQ-021 A transfer occurs on valid&&ready: the requester's fields and operands are captured and the last-grant pointer is set to N; next state is EXEC.
REQ-022 EXEC: alu_* outputs SHALL drive the captured fields; alu_result_i is registered into rsp_data_o with rsp_id_o=N; next state is RESP.
REQ-023 RESP: rsp_valid_o=1 and data/id are held stable until rsp_ready_i=1, then the FSM returns to IDLE on the next edge.
REQ-024 Latency: transfer at edge N, rsp_valid_o high from N+2; minimum of 3 cycles per operation.
REQ-025 Outside EXEC, all alu_* outputs SHALL be zero.
REQ-026 If a requester drops valid before ready is asserted, no transfer occurs and the pointer is unchanged.
REQ-027 If rsp_ready_i stays low, the FSM SHALL remain in RESP indefinitely and accept no new requests.
REQ-028 If rsp_ready_i is high on RESP entry, the response SHALL last exactly one cycle.
REQ-029 Results SHALL be passed through unmodified, with no width change.

Reset
REQ-030 While reset=0: state=IDLE, last-grant pointer=1 (requester 0 preferred first), captured fields=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, busy_o=0.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight operation; it SHALL produce no response after reset release.

Structure
REQ-032 State encodings (IDLE/EXEC/RESP) and DATA_WIDTH default SHALL live in the shared package.
REQ-033 One sub-module, rr_grant2 (two-way round-robin grant: valids + last pointer -> one-hot grant), SHALL be used.

Verification
Bench ALU model: op 000/f3 000 -> a+b (funct7=1 -> a-b); op 111 -> b.
REQ-034 Single request: req0 ADD a=5, b=7 at edge N -> alu_op_o=000 in EXEC; rsp_valid_o=1 with rsp_data_o=12 and rsp_id_o=0 at N+2.
REQ-035 Simultaneous requests after reset: req0 SUB 9-4 and req1 ADD 1+2 held -> responses are 5 (id 0), then 3 (id 1); next contended grant goes to req0.
REQ-036 Backpressure: rsp_ready_i=0 for 10 cycles -> rsp_data/id held, both ready outputs stay 0, busy_o=1; release -> IDLE one cycle later.
REQ-037 Withdrawn request: req1_valid_i pulses low before grant -> no transfer and no response.
REQ-038 Reset in EXEC: assert reset=0 -> rsp_valid_o=0 and busy_o=0 immediately, with no stale response afterward.
REQ-039 LUI pass-through: req1 op 111, b=0x12345000 -> rsp_data_o=0x12345000, rsp_id_o=1.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared types and defaults for the two-way ALU share arbiter
package alu_share_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, shared-ALU and response signal bundle
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = alu_share_arbiter_pkg::DATA_WIDTH_DEF
);
    logic                  req0_valid_i;
    logic                  req0_ready_o;
    logic                  req0_funct7_i;
    logic [2:0]            req0_alu_op_i;
    logic [2:0]            req0_funct3_i;
    logic [DATA_WIDTH-1:0] req0_a_i;
    logic [DATA_WIDTH-1:0] req0_b_i;

    logic                  req1_valid_i;
    logic                  req1_ready_o;
    logic                  req1_funct7_i;
    logic [2:0]            req1_alu_op_i;
    logic [2:0]            req1_funct3_i;
    logic [DATA_WIDTH-1:0] req1_a_i;
    logic [DATA_WIDTH-1:0] req1_b_i;

    logic                  alu_funct7_o;
    logic [2:0]            alu_op_o;
    logic [2:0]            alu_funct3_o;
    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic [DATA_WIDTH-1:0] alu_result_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_id_o;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  busy_o;

    modport slave (
        input  req0_valid_i, req0_funct7_i, req0_alu_op_i, req0_funct3_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_funct7_i, req1_alu_op_i, req1_funct3_i, req1_a_i, req1_b_i,
        input  alu_result_i, rsp_ready_i,
        output req0_ready_o, req1_ready_o,
        output alu_funct7_o, alu_op_o, alu_funct3_o, alu_a_o, alu_b_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

    modport master (
        output req0_valid_i, req0_funct7_i, req0_alu_op_i, req0_funct3_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_funct7_i, req1_alu_op_i, req1_funct3_i, req1_a_i, req1_b_i,
        output alu_result_i, rsp_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_funct7_o, alu_op_o, alu_funct3_o, alu_a_o, alu_b_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );
endinterface

// File: rtl/alu_share_arbiter_rr_grant2.sv
// rtl/alu_share_arbiter_rr_grant2.sv - two-way round-robin grant, one-hot output
module rr_grant2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);
    // Under contention the requester that was not granted last wins.
    assign o_grant[0] = i_valid[0] & (~i_valid[1] | i_last);
    assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last);
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_xfer;
    logic                  w_sel;

    logic                  r_funct7;
    logic [2:0]            r_op;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_id;
    logic                  r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    assign w_valid = {bus.req1_valid_i, bus.req0_valid_i};

    rr_grant2 u_grant (
        .i_valid (w_valid),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_xfer = (r_state == ST_IDLE) && (|w_grant);
    assign w_sel  = w_grant[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        bus.req0_ready_o = 1'b0;
        bus.req1_ready_o = 1'b0;
        bus.alu_funct7_o = 1'b0;
        bus.alu_op_o     = 3'd0;
        bus.alu_funct3_o = 3'd0;
        bus.alu_a_o      = '0;
        bus.alu_b_o      = '0;
        case (r_state)
            ST_IDLE: begin
                bus.req0_ready_o = w_grant[0];
                bus.req1_ready_o = w_grant[1];
                if (w_xfer) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                bus.alu_funct7_o = r_funct7;
                bus.alu_op_o     = r_op;
                bus.alu_funct3_o = r_funct3;
                bus.alu_a_o      = r_a;
                bus.alu_b_o      = r_b;
                w_next           = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture on transfer; the ALU result is registered on the single EXEC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last     <= 1'b1;
            r_funct7   <= 1'b0;
            r_op       <= 3'd0;
            r_funct3   <= 3'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_xfer) begin
                r_last   <= w_sel;
                r_id     <= w_sel;
                r_funct7 <= w_sel ? bus.req1_funct7_i : bus.req0_funct7_i;
                r_op     <= w_sel ? bus.req1_alu_op_i : bus.req0_alu_op_i;
                r_funct3 <= w_sel ? bus.req1_funct3_i : bus.req0_funct3_i;
                r_a      <= w_sel ? bus.req1_a_i      : bus.req0_a_i;
                r_b      <= w_sel ? bus.req1_b_i      : bus.req0_b_i;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data <= bus.alu_result_i;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign bus.rsp_valid_o = (r_state == ST_RESP);
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Shared ALU model: add/sub for op 000 funct3 000, pass b for op 111.
    always_comb begin
        bus.alu_result_i = '0;
        if (bus.alu_op_o == 3'b111)
            bus.alu_result_i = bus.alu_b_o;
        else if (bus.alu_op_o == 3'b000 && bus.alu_funct3_o == 3'b000)
            bus.alu_result_i = bus.alu_funct7_o ? (bus.alu_a_o - bus.alu_b_o)
                                                : (bus.alu_a_o + bus.alu_b_o);
    end

    typedef struct {
        logic          sel;
        logic          f7;
        logic [2:0]    op;
        logic [2:0]    f3;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    bit   ok;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid_i  = 1'b0; bus.req1_valid_i  = 1'b0;
        bus.req0_funct7_i = 1'b0; bus.req1_funct7_i = 1'b0;
        bus.req0_alu_op_i = 3'd0; bus.req1_alu_op_i = 3'd0;
        bus.req0_funct3_i = 3'd0; bus.req1_funct3_i = 3'd0;
        bus.req0_a_i      = '0;   bus.req1_a_i      = '0;
        bus.req0_b_i      = '0;   bus.req1_b_i      = '0;
    endtask

    task automatic drive_req(input logic sel, input logic f7, input logic [2:0] op,
                             input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (sel) begin
            bus.req1_funct7_i = f7; bus.req1_alu_op_i = op; bus.req1_funct3_i = f3;
            bus.req1_a_i = a; bus.req1_b_i = b; bus.req1_valid_i = 1'b1;
        end else begin
            bus.req0_funct7_i = f7; bus.req0_alu_op_i = op; bus.req0_funct3_i = f3;
            bus.req0_a_i = a; bus.req0_b_i = b; bus.req0_valid_i = 1'b1;
        end
    endtask

    // Called just after a negedge; returns with the transfer due on the next posedge.
    task automatic wait_ready(input logic sel, output bit got);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if ((sel ? bus.req1_ready_o : bus.req0_ready_o) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("grant_wait", got, 1'b1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit g;
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        drive_req(v.sel, v.f7, v.op, v.f3, v.a, v.b);
        wait_ready(v.sel, g);
        if (!g) begin
            clear_reqs();
            return;
        end
        @(negedge clk);
        clear_reqs();
        chk($sformatf("v%0d_alu_op", idx), bus.alu_op_o, v.op);
        chk($sformatf("v%0d_alu_a", idx), bus.alu_a_o, v.a);
        chk($sformatf("v%0d_alu_b", idx), bus.alu_b_o, v.b);
        chk($sformatf("v%0d_exec_busy", idx), bus.busy_o, 1'b1);
        chk($sformatf("v%0d_exec_ready", idx), {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", idx), bus.rsp_valid_o, 1'b1);
        chk($sformatf("v%0d_rsp_data", idx), bus.rsp_data_o, v.exp);
        chk($sformatf("v%0d_rsp_id", idx), bus.rsp_id_o, v.sel);
        chk($sformatf("v%0d_resp_alu_zero", idx), bus.alu_a_o | bus.alu_b_o, '0);
        @(negedge clk);
        chk($sformatf("v%0d_idle_busy", idx), bus.busy_o, 1'b0);
        chk($sformatf("v%0d_idle_valid", idx), bus.rsp_valid_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 3'b000, 3'b000, 32'd5,        32'd7,        32'd12};
        vecs[1] = '{1'b0, 1'b1, 3'b000, 3'b000, 32'd9,        32'd4,        32'd5};
        vecs[2] = '{1'b1, 1'b0, 3'b111, 3'b000, 32'h0000dead, 32'h12345000, 32'h12345000};
        vecs[3] = '{1'b1, 1'b0, 3'b000, 3'b000, 32'hffffffff, 32'd1,        32'h00000000};
        vecs[4] = '{1'b0, 1'b1, 3'b000, 3'b000, 32'd0,        32'd1,        32'hffffffff};
        vecs[5] = '{1'b1, 1'b0, 3'b000, 3'b000, 32'h7fffffff, 32'd1,        32'h80000000};
        vecs[6] = '{1'b0, 1'b0, 3'b111, 3'b000, 32'd3,        32'hffffffff, 32'hffffffff};

        clear_reqs();
        bus.rsp_ready_i = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_rsp_data", bus.rsp_data_o, '0);
        chk("rst_rsp_id", bus.rsp_id_o, 1'b0);
        chk("rst_ready", {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
        chk("rst_alu_op", bus.alu_op_o, 3'd0);
        reset = 1'b1;

        // Contention straight out of reset: req0 first, then req1, then req0 again.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 3'b000, 3'b000, 32'd9, 32'd4);
        drive_req(1'b1, 1'b0, 3'b000, 3'b000, 32'd1, 32'd2);
        #1;
        chk("cont_first_ready", {bus.req1_ready_o, bus.req0_ready_o}, 2'b01);
        @(negedge clk);
        bus.req0_valid_i = 1'b0;
        chk("cont_exec_f7", bus.alu_funct7_o, 1'b1);
        chk("cont_exec_ready1", bus.req1_ready_o, 1'b0);
        @(negedge clk);
        chk("cont_rsp0_data", bus.rsp_data_o, 32'd5);
        chk("cont_rsp0_id", bus.rsp_id_o, 1'b0);
        @(negedge clk);
        #1;
        chk("cont_second_ready", {bus.req1_ready_o, bus.req0_ready_o}, 2'b10);
        @(negedge clk);
        bus.req1_valid_i = 1'b0;
        @(negedge clk);
        chk("cont_rsp1_data", bus.rsp_data_o, 32'd3);
        chk("cont_rsp1_id", bus.rsp_id_o, 1'b1);
        @(negedge clk);
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        #1;
        chk("cont_third_ready", {bus.req1_ready_o, bus.req0_ready_o}, 2'b01);
        clear_reqs();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Backpressure: hold the response 10 cycles while req1 waits.
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        drive_req(1'b0, 1'b0, 3'b000, 3'b000, 32'd20, 32'd22);
        wait_ready(1'b0, ok);
        @(negedge clk);
        clear_reqs();
        drive_req(1'b1, 1'b0, 3'b000, 3'b000, 32'd1, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", bus.rsp_valid_o, 1'b1);
            chk("bp_rsp_data", bus.rsp_data_o, 32'd42);
            chk("bp_rsp_id", bus.rsp_id_o, 1'b0);
            chk("bp_ready", {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
            chk("bp_busy", bus.busy_o, 1'b1);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_busy", bus.busy_o, 1'b0);
        chk("bp_release_valid", bus.rsp_valid_o, 1'b0);
        chk("bp_release_ready1", bus.req1_ready_o, 1'b1);
        clear_reqs();

        // Withdrawn request: req1 pulses while the arbiter is stuck in RESP.
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        drive_req(1'b0, 1'b0, 3'b000, 3'b000, 32'd2, 32'd2);
        wait_ready(1'b0, ok);
        @(negedge clk);
        clear_reqs();
        drive_req(1'b1, 1'b0, 3'b000, 3'b000, 32'd8, 32'd8);
        @(negedge clk);
        chk("wd_rsp_data", bus.rsp_data_o, 32'd4);
        bus.req1_valid_i = 1'b0;
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("wd_no_busy", bus.busy_o, 1'b0);
            chk("wd_no_rsp", bus.rsp_valid_o, 1'b0);
        end
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        #1;
        chk("wd_pointer", {bus.req1_ready_o, bus.req0_ready_o}, 2'b10);
        clear_reqs();

        // Reset while in EXEC discards the operation.
        @(negedge clk);
        drive_req(1'b1, 1'b0, 3'b000, 3'b000, 32'd3, 32'd4);
        wait_ready(1'b1, ok);
        @(negedge clk);
        clear_reqs();
        chk("rexec_busy_before", bus.busy_o, 1'b1);
        reset = 1'b0;
        #1;
        chk("rexec_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk("rexec_busy", bus.busy_o, 1'b0);
        chk("rexec_alu_a", bus.alu_a_o, '0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rexec_no_rsp", bus.rsp_valid_o, 1'b0);
            chk("rexec_no_busy", bus.busy_o, 1'b0);
        end
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        #1;
        chk("rexec_pointer", {bus.req1_ready_o, bus.req0_ready_o}, 2'b01);
        clear_reqs();

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
